// File: rtl/aha_clk_seq_pkg.sv
// Shared types and helpers for the clock-switch sequencer: FSM state encoding,
// select-field width and the clamp applied to requested divider selects.
package aha_clk_seq_pkg;

  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_MAX = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GATE   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_SWITCH = 3'd3,
    ST_SETTLE = 3'd4,
    ST_UNGATE = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  // Selects above /32 do not exist in the clock selector; saturate them.
  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
    return (s > SEL_MAX) ? SEL_MAX : s;
  endfunction

endpackage

// File: rtl/aha_clk_seq_rr_arbiter.sv
// NUM_DOM-way round-robin arbiter: grants the first requester at or after the
// pointer; the pointer moves to one past the served domain when advance pulses.
module aha_clk_seq_rr_arbiter #(
  parameter int NUM_DOM = 4,
  parameter int IDX_W   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_DOM-1:0] req,
  input  logic               advance,
  input  logic [IDX_W-1:0]   adv_idx,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  int unsigned      k;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    k           = 0;
    for (int i = NUM_DOM - 1; i >= 0; i--) begin
      k = (int'(ptr_q) + i) % NUM_DOM;
      if (req[k]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(k);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (int'(adv_idx) == NUM_DOM - 1) ? '0 : adv_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/aha_clock_switch_sequencer.sv
// Glitch-safe divider-select sequencer shared by all clock domains.
// Optional build macro AHA_CLK_SEQ_SKIP_SAME_EN: requests for the current select ack without gating.
module aha_clock_switch_sequencer
  import aha_clk_seq_pkg::*;
#(
  parameter int NUM_DOM    = 4,
  parameter int DRAIN_CYC  = 64,
  parameter int SETTLE_CYC = 64,
  parameter int RESET_SEL  = 0
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NUM_DOM-1:0]       REQ_VALID,
  input  logic [SEL_W*NUM_DOM-1:0] REQ_SEL,
  input  logic [NUM_DOM-1:0]       SW_GATE,
  output logic [SEL_W*NUM_DOM-1:0] SEL_OUT,
  output logic [NUM_DOM-1:0]       GATE_OUT,
  output logic [NUM_DOM-1:0]       ACK,
  output logic                     BUSY,
  output logic [2:0]               DBG_STATE
);

  localparam int IDX_W   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam int CNT_MAX = (DRAIN_CYC > SETTLE_CYC) ? DRAIN_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [SEL_W-1:0] RST_SEL_V = SEL_W'(RESET_SEL);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         gidx_q, gidx_d;
  logic [SEL_W-1:0]         lsel_q, lsel_d;
  logic [SEL_W*NUM_DOM-1:0] sel_q, sel_d;
  logic [NUM_DOM-1:0]       gate_q, gate_d;
  logic [NUM_DOM-1:0]       ack_q, ack_d;

  logic                     grant_valid;
  logic [IDX_W-1:0]         grant_idx;
  logic                     advance;
  int unsigned              gbase;
  int unsigned              cbase;
  logic [SEL_W-1:0]         req_sel_c;

  aha_clk_seq_rr_arbiter #(
    .NUM_DOM (NUM_DOM),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk         (CLK),
    .rst         (RESET),
    .req         (REQ_VALID),
    .advance     (advance),
    .adv_idx     (gidx_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    gbase     = int'(grant_idx) * SEL_W;
    cbase     = int'(gidx_q) * SEL_W;
    req_sel_c = clamp_sel(REQ_SEL[gbase +: SEL_W]);
  end

  // Each output register is written on entry to the state that owns it, so the
  // gate is up for exactly DRAIN_CYC cycles before the new select appears.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gidx_d  = gidx_q;
    lsel_d  = lsel_q;
    sel_d   = sel_q;
    gate_d  = gate_q;
    ack_d   = '0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          gidx_d  = grant_idx;
          lsel_d  = req_sel_c;
          state_d = ST_GATE;
`ifdef AHA_CLK_SEQ_SKIP_SAME_EN
          if (req_sel_c == sel_q[gbase +: SEL_W]) begin
            state_d          = ST_DONE;
            ack_d[grant_idx] = 1'b1;
          end
`endif
        end
      end
      ST_GATE: begin
        gate_d[gidx_q] = 1'b1;
        cnt_d          = CNT_W'(DRAIN_CYC - 1);
        state_d        = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          sel_d[cbase +: SEL_W] = lsel_q;
          state_d               = ST_SWITCH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SWITCH: begin
        cnt_d   = CNT_W'(SETTLE_CYC - 1);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          gate_d[gidx_q] = 1'b0;
          state_d        = ST_UNGATE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_UNGATE: begin
        ack_d[gidx_q] = 1'b1;
        state_d       = ST_DONE;
      end
      ST_DONE: begin
        advance = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gidx_q  <= '0;
      lsel_q  <= '0;
      sel_q   <= {NUM_DOM{RST_SEL_V}};
      gate_q  <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gidx_q  <= gidx_d;
      lsel_q  <= lsel_d;
      sel_q   <= sel_d;
      gate_q  <= gate_d;
      ack_q   <= ack_d;
    end
  end

  assign SEL_OUT   = sel_q;
  assign GATE_OUT  = SW_GATE | gate_q;
  assign ACK       = ack_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_aha_clock_switch_sequencer.sv
// Self-checking bench for aha_clock_switch_sequencer: a round-robin model
// predicts each ACK (domain, select, latency) into a queue checked on ACK.
module tb_aha_clock_switch_sequencer;

  localparam int ND     = 4;
  localparam int DRAIN  = 64;
  localparam int SETTLE = 64;
  // Latency measured from the first BUSY cycle (one cycle after grant) to ACK.
  localparam int LAT_FULL = DRAIN + SETTLE + 3;
`ifdef AHA_CLK_SEQ_SKIP_SAME_EN
  localparam logic SKIP_EN = 1'b1;
`else
  localparam logic SKIP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [11:0] req_sel;
  logic [3:0]  sw_gate;
  logic [11:0] sel_out;
  logic [3:0]  gate_out;
  logic [3:0]  ack;
  logic        busy;
  logic [2:0]  dbg_state;

  aha_clock_switch_sequencer dut (
    .CLK       (clk),
    .RESET     (rst),
    .REQ_VALID (req_valid),
    .REQ_SEL   (req_sel),
    .SW_GATE   (sw_gate),
    .SEL_OUT   (sel_out),
    .GATE_OUT  (gate_out),
    .ACK       (ack),
    .BUSY      (busy),
    .DBG_STATE (dbg_state)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          busy_rise = -1;
  logic        busy_prev = 1'b0;
  logic [3:0]  gate_seen;
  logic [12:0] exp_q[$];
  logic [2:0]  mdl_sel[ND];
  int          mdl_ptr;

  function automatic logic [2:0] exp_clamp(input logic [2:0] s);
    return (s >= 3'd6) ? 3'd5 : s;
  endfunction

  function automatic logic [11:0] mdl_sel_vec();
    logic [11:0] v;
    for (int d = 0; d < ND; d++) v[d*3 +: 3] = mdl_sel[d];
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic mdl_reset();
    for (int d = 0; d < ND; d++) mdl_sel[d] = 3'd0;
    mdl_ptr = 0;
  endtask

  // One clock: sample at the falling edge and run the ACK scoreboard.
  task automatic tick();
    logic [12:0] e;
    int          idx;
    @(negedge clk);
    cyc++;
    if (cyc > 60000) begin
      $display("FAIL watchdog: got cycle %0d expected below 60000", cyc);
      $fatal(1, "watchdog expired");
    end
    if (busy && !busy_prev) busy_rise = cyc;
    busy_prev = busy;
    gate_seen = gate_seen | (gate_out & ~sw_gate);
    if (ack != 4'd0) begin
      check("ack_onehot", $countones(ack), 1);
      idx = 0;
      for (int d = 0; d < ND; d++) if (ack[d]) idx = d;
      if (exp_q.size() == 0) begin
        check("ack_unexpected", ack, 0);
      end else begin
        e = exp_q.pop_front();
        check("ack_dom", idx, e[12:11]);
        check("ack_sel", sel_out[idx*3 +: 3], e[10:8]);
        check("ack_latency", cyc - busy_rise, e[7:0]);
      end
      req_valid[idx] = 1'b0;
    end
  endtask

  // Predict grant order for requests raised together, then raise them.
  task automatic push_round(input logic [3:0] mask);
    int         k;
    int         last;
    int         lat;
    logic [2:0] s;
    last = -1;
    for (int i = 0; i < ND; i++) begin
      k = (mdl_ptr + i) % ND;
      if (mask[k]) begin
        s   = exp_clamp(req_sel[k*3 +: 3]);
        lat = (SKIP_EN && (s == mdl_sel[k])) ? 0 : LAT_FULL;
        exp_q.push_back({k[1:0], s, lat[7:0]});
        mdl_sel[k] = s;
        last = k;
      end
    end
    if (last >= 0) mdl_ptr = (last + 1) % ND;
    req_valid = req_valid | mask;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    check(tag, (exp_q.size() != 0) || busy, 0);
    tick();
  endtask

  task automatic wait_busy_rise();
    int start;
    start = cyc;
    while (busy_rise <= start && cyc - start < 20) tick();
    check("grant_seen", busy_rise > start, 1);
  endtask

  initial begin
    int         g;
    logic [3:0] m;
    logic [2:0] s;

    rst       = 1'b1;
    req_valid = 4'd0;
    req_sel   = 12'd0;
    sw_gate   = 4'($urandom_range(0, 15));
    gate_seen = 4'd0;
    mdl_reset();
    repeat (3) tick();
    check("rst_sel", sel_out, 12'd0);
    check("rst_gate", gate_out, sw_gate);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    rst     = 1'b0;
    sw_gate = 4'd0;
    repeat (2) tick();

    // Single request with cycle-exact gate/select/ack timing.
    req_sel[8:6] = 3'd3;
    push_round(4'b0100);
    wait_busy_rise();
    g = busy_rise;
    check("gate_in_gate_state", gate_out[2], 0);
    for (int off = 1; off <= 131; off++) begin
      tick();
      if (off == 1)   check("gate_rise", gate_out[2], 1);
      if (off == 50)  check("other_gates", gate_out & 4'b1011, 0);
      if (off == 64)  check("sel_before_switch", sel_out[8:6], 0);
      if (off == 65)  check("sel_after_drain", sel_out[8:6], 3);
      if (off == 129) check("gate_held", gate_out[2], 1);
      if (off == 130) check("gate_fall", gate_out[2], 0);
    end
    check("single_ack_cycle", cyc - g, 131);
    wait_idle(20, "single_done");
    check("single_sel_all", sel_out, mdl_sel_vec());

    // Contention from reset: pointer at domain 0, expect 0, 1, 3.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mdl_reset();
    tick();
    for (int d = 0; d < ND; d++) req_sel[d*3 +: 3] = 3'($urandom_range(0, 4));
    push_round(4'b1011);
    wait_idle(600, "contention_done");
    check("contention_sel_all", sel_out, mdl_sel_vec());

    // Clamp; late REQ_SEL change and early REQ_VALID drop are ignored.
    req_sel[5:3] = 3'd7;
    push_round(4'b0010);
    wait_busy_rise();
    req_sel[5:3]  = 3'd2;
    req_valid[1]  = 1'b0;
    wait_idle(200, "clamp_done");
    check("clamp_sel", sel_out[5:3], 5);

    // Re-request the current select.
    gate_seen    = 4'd0;
    req_sel[5:3] = mdl_sel[1];
    push_round(4'b0010);
    wait_idle(200, "same_done");
    check("same_gate_seen", gate_seen[1], !SKIP_EN);

    // Software gate held across a sequence.
    sw_gate      = 4'b0001;
    req_sel[2:0] = 3'd2;
    push_round(4'b0001);
    wait_idle(200, "swgate_done");
    check("swgate_held", gate_out[0], 1);
    check("swgate_sel", sel_out[2:0], 2);
    sw_gate = 4'd0;
    tick();
    check("swgate_release", gate_out, 0);

    // Random request sets and selects against the model.
    for (int r = 0; r < 6; r++) begin
      m       = 4'($urandom_range(1, 15));
      req_sel = 12'($urandom());
      push_round(m);
      wait_idle(600, "random_done");
      check("random_sel_all", sel_out, mdl_sel_vec());
    end

    // Reset during DRAIN: request lost, outputs back to reset values at once.
    s = (mdl_sel[3] == 3'd4) ? 3'd1 : 3'd4;
    req_sel[11:9] = s;
    req_valid[3]  = 1'b1;
    wait_busy_rise();
    repeat (20) tick();
    check("mid_gate", gate_out[3], 1);
    sw_gate   = 4'b0101;
    rst       = 1'b1;
    req_valid = 4'd0;
    #1;
    check("mid_rst_gate", gate_out, 4'b0101);
    check("mid_rst_sel", sel_out, 12'd0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ack", ack, 0);
    mdl_reset();
    repeat (2) tick();
    rst = 1'b0;
    repeat (150) tick();
    check("post_rst_sel", sel_out, 12'd0);
    check("post_rst_queue", exp_q.size(), 0);
    sw_gate = 4'd0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
